// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared FSM states, BCD width and sizing helpers for the digit scanner
package seg7_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } fsm_state_e;

    // Width needed to index n items; never narrower than one bit
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // 10^n as a 64-bit constant, used for the display overflow limit
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// rtl/bcd_double_dabble.sv - sequential binary-to-BCD converter, one shift per clock
module bcd_double_dabble
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [VALUE_W-1:0]            i_value,
    output logic                          o_last,
    output logic [NUM_DIGITS*BCD_W-1:0]   o_bcd
);

    localparam int SCR_W = NUM_DIGITS * BCD_W;
    localparam int CNT_W = clog2(VALUE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

    logic [VALUE_W-1:0] r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic [SCR_W-1:0]   w_adj;

    // Add-3 correction on every nibble that would overflow past 9 when doubled;
    // bits carried out of the top nibble are dropped (overflow is judged elsewhere)
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scratch[i*BCD_W +: BCD_W] >= 4'd5) begin
                w_adj[i*BCD_W +: BCD_W] = r_scratch[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    // Load on start, then shift the binary MSB into the corrected scratch each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_active  <= 1'b0;
        end else if (i_start) begin
            r_shift   <= i_value;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_active  <= 1'b1;
        end else if (r_active) begin
            r_scratch <= SCR_W'({w_adj, r_shift[VALUE_W-1]});
            r_shift   <= r_shift << 1;
            if (r_cnt == CNT_LAST) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_last = r_active && (r_cnt == CNT_LAST);
    assign o_bcd  = r_scratch;

endmodule

// File: rtl/bcd_digit_scan.sv
// rtl/bcd_digit_scan.sv - binary to BCD conversion with multiplexed 7-seg digit scan (LEADING_ZERO_BLANK_EN blanks leading zeros)
module bcd_digit_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value_in,
    output logic                  busy,
    output logic                  ovf,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int DISP_W = NUM_DIGITS * BCD_W;
    localparam int IDX_W  = clog2(NUM_DIGITS);
    localparam int RC_W   = clog2(REFRESH_DIV);
    localparam logic [63:0]           OVF_LIMIT = pow10(NUM_DIGITS);
    localparam logic [DISP_W-1:0]     ALL_NINES = {NUM_DIGITS{4'd9}};
    localparam logic [NUM_DIGITS-1:0] POS0      = NUM_DIGITS'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [RC_W-1:0]       RC_LAST   = RC_W'(REFRESH_DIV - 1);
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~POS0;
`else
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

    fsm_state_e            r_state;
    logic                  r_busy;
    logic                  r_ovf;
    logic                  r_ovf_pend;
    logic [DISP_W-1:0]     r_disp;
    logic [NUM_DIGITS-1:0] r_blank;
    logic [RC_W-1:0]       r_refresh;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_digit;
    logic [NUM_DIGITS-1:0] r_sel;

    logic                  w_start;
    logic                  w_ovf_in;
    logic                  w_dd_last;
    logic [DISP_W-1:0]     w_bcd;
    logic [DISP_W-1:0]     w_commit_val;
    logic [NUM_DIGITS-1:0] w_blank_nxt;
    logic                  w_term;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [3:0]            w_digit_nxt;
    logic [NUM_DIGITS-1:0] w_sel_nxt;

    assign w_start      = (r_state == ST_IDLE) && load;
    assign w_ovf_in     = 64'(value_in) >= OVF_LIMIT;
    assign w_commit_val = r_ovf_pend ? ALL_NINES : w_bcd;

    bcd_double_dabble #(
        .NUM_DIGITS (NUM_DIGITS),
        .VALUE_W    (VALUE_W)
    ) u_dd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_value (value_in),
        .o_last  (w_dd_last),
        .o_bcd   (w_bcd)
    );

    // Blank mask for the value about to be committed: every position above the highest non-zero nibble
    always_comb begin
        w_blank_nxt = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic w_nz;
            w_nz = 1'b0;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                w_nz           = w_nz | (w_commit_val[i*BCD_W +: BCD_W] != 4'd0);
                w_blank_nxt[i] = ~w_nz;
            end
        end
`endif
    end

    // Conversion sequencing: capture, wait for the last shift, then publish the result atomically
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_disp     <= '0;
            r_blank    <= BLANK_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_state    <= ST_SHIFT;
                        r_busy     <= 1'b1;
                        r_ovf_pend <= w_ovf_in;
                    end
                end
                ST_SHIFT: begin
                    if (w_dd_last) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_disp  <= w_commit_val;
                    r_ovf   <= r_ovf_pend;
                    r_blank <= w_blank_nxt;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_term    = (r_refresh == RC_LAST);
    assign w_idx_nxt = !w_term ? r_idx :
                       (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

    // Select the digit and enable pattern for the position that is current after this edge
    always_comb begin
        w_digit_nxt = 4'd0;
        w_sel_nxt   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == w_idx_nxt) begin
                w_digit_nxt  = r_disp[i*BCD_W +: BCD_W];
                w_sel_nxt[i] = r_blank[i];
            end
        end
    end

    // Free-running refresh divider and scan position with registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_digit   <= 4'd0;
            r_sel     <= ~POS0;
        end else begin
            r_refresh <= w_term ? '0 : r_refresh + RC_W'(1);
            r_idx     <= w_idx_nxt;
            r_digit   <= w_digit_nxt;
            r_sel     <= w_sel_nxt;
        end
    end

    assign busy      = r_busy;
    assign ovf       = r_ovf;
    assign digit     = r_digit;
    assign digit_sel = r_sel;

endmodule

// File: tb/tb_bcd_digit_scan.sv
// tb/tb_bcd_digit_scan.sv - scoreboard bench for bcd_digit_scan (honours LEADING_ZERO_BLANK_EN)
module tb_bcd_digit_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [13:0] value_in;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit;
    logic [3:0]  digit_sel;

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_digit_scan #(
        .NUM_DIGITS  (4),
        .VALUE_W     (14),
        .REFRESH_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value_in  (value_in),
        .busy      (busy),
        .ovf       (ovf),
        .digit     (digit),
        .digit_sel (digit_sel)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int sel_pos(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            4'b1111: return -1;
            default: return -2;
        endcase
    endfunction

    function automatic int next_lit(input int p, input logic [3:0] bl);
        int q;
        q = p;
        for (int k = 0; k < 4; k++) begin
            q = (q + 1) % 4;
            if (!bl[q]) return q;
        end
        return p;
    endfunction

    // Pulse load for one cycle and record the hand-computed display expectation
    task automatic issue(input logic [13:0] v, input logic [15:0] bcd, input logic o);
        exp_q.push_back({o, bcd});
        load     = 1'b1;
        value_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_only(input logic [13:0] v);
        load     = 1'b1;
        value_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, input bit hold, output int bad);
        cyc = 0;
        bad = 0;
        while (busy && cyc < 100) begin
            if (hold && digit !== 4'd0) bad++;
            cyc++;
            @(negedge clk);
        end
        chk("busy_ends", busy, 0);
    endtask

    // Monitor: each busy fall is a commit; pop the expectation and watch one full scan rotation
    initial begin : monitor
        logic        prev_busy;
        logic [16:0] e;
        logic [15:0] eb;
        logic [3:0]  bl;
        logic [3:0]  gotd[4];
        int          seen[4];
        int          dark, badsel, order_bad, prev_pos, pos;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_commit", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        eb = e[15:0];
                        chk("ovf", ovf, e[16]);
                        bl = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
                        for (int p = 1; p < 4; p++) begin
                            bl[p] = !e[16] && ((eb >> (4 * p)) == 16'd0);
                        end
`endif
                        for (int p = 0; p < 4; p++) begin
                            seen[p] = 0;
                            gotd[p] = eb[4*p +: 4];
                        end
                        dark = 0; badsel = 0; order_bad = 0; prev_pos = -1;
                        @(negedge clk);
                        for (int c = 0; c < 16; c++) begin
                            @(negedge clk);
                            pos = sel_pos(digit_sel);
                            if (pos >= 0) begin
                                seen[pos]++;
                                if (digit !== eb[4*pos +: 4]) gotd[pos] = digit;
                                if (prev_pos >= 0 && pos != prev_pos && pos != next_lit(prev_pos, bl))
                                    order_bad++;
                                prev_pos = pos;
                            end else if (pos == -1) begin
                                dark++;
                            end else begin
                                badsel++;
                            end
                        end
                        for (int p = 0; p < 4; p++) begin
                            chk($sformatf("slots_pos%0d", p), seen[p], bl[p] ? 0 : 4);
                            if (!bl[p] && seen[p] > 0)
                                chk($sformatf("digit_pos%0d", p), gotd[p], eb[4*p +: 4]);
                        end
                        chk("dark_slots", dark, 4 * $countones(bl));
                        chk("bad_sel", badsel, 0);
                        chk("scan_order", order_bad, 0);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        int cyc, bad;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_digit", digit, 0);
        chk("rst_sel", digit_sel, 4'b1110);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1234: busy length and scan order 4,3,2,1
        issue(14'd1234, 16'h1234, 1'b0);
        wait_idle(cyc, 1'b1, bad);
        chk("busy_cycles_1234", cyc, 15);
        chk("hold_zero_1234", bad, 0);
        repeat (26) @(negedge clk);

        // largest in-range value, then first overflowing value
        issue(14'd9999, 16'h9999, 1'b0);
        wait_idle(cyc, 1'b0, bad);
        chk("busy_cycles_9999", cyc, 15);
        repeat (26) @(negedge clk);
        issue(14'd10000, 16'h9999, 1'b1);
        wait_idle(cyc, 1'b0, bad);
        repeat (26) @(negedge clk);

        // asynchronous reset between edges while ovf=1
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_ovf", ovf, 0);
        chk("async_digit", digit, 0);
        chk("async_sel", digit_sel, 4'b1110);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 42 then 7 while busy: 7 dropped, display holds 0000 until commit
        issue(14'd42, 16'h0042, 1'b0);
        bad = 0;
        repeat (3) begin
            if (digit !== 4'd0) bad++;
            @(negedge clk);
        end
        pulse_only(14'd7);
        wait_idle(cyc, 1'b1, cyc);
        chk("hold_zero_42", bad + cyc, 0);
        repeat (26) @(negedge clk);

        // small values: blanking behaviour when enabled, plain digits otherwise
        issue(14'd5, 16'h0005, 1'b0);
        wait_idle(cyc, 1'b0, bad);
        repeat (26) @(negedge clk);
        issue(14'd0, 16'h0000, 1'b0);
        wait_idle(cyc, 1'b0, bad);
        repeat (26) @(negedge clk);

        // reset five cycles into a conversion of 8888: nothing may commit
        pulse_only(14'd8888);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_digit", digit, 0);
        chk("abort_sel", digit_sel, 4'b1110);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (digit !== 4'd0) bad++;
            if (busy) cyc++;
        end
        chk("abort_digit_zero", bad, 0);
        chk("abort_no_busy", cyc, 0);

        chk("pending_expect", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
